cache_tag_ctrl: RTL
===================

Name: cache_tag_ctrl

Overview:
- Sequencing and arbitration controller for the per-processor cache tag RAM: single-port, synchronous read, entry = {MSI state[1:0], tag}.
- Shares the one RAM port between the local CPU (lookup/fill) and the bus snoop side (BusRd/BusRdX).
- Performs read-compare-update as one atomic sequence and reports hit, state and flush to the requester.

Parameters:
- AWIDTH, 3: tag RAM index width; depth = 1<<AWIDTH.
- DWIDTH, 11: tag RAM entry width; TWIDTH = DWIDTH-2 tag bits, top 2 bits are MSI state.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request, level, held until cpu_ack.
- cpu_op  in  1  0 = lookup, 1 = fill (write tag/state).
- cpu_index  in  AWIDTH  set index.
- cpu_tag  in  TWIDTH  tag to compare/write.
- cpu_state_in  in  2  state written on fill.
- cpu_ack  out  1  one-cycle done pulse.
- cpu_hit  out  1  tag match and state != I.
- cpu_state_out  out  2  entry state before any update.
- snp_req  in  1  snoop request, level, held until snp_ack.
- snp_op  in  1  0 = BusRd, 1 = BusRdX.
- snp_index  in  AWIDTH  set index.
- snp_tag  in  TWIDTH  tag to compare.
- snp_ack  out  1  one-cycle done pulse.
- snp_hit  out  1  snoop hit.
- snp_flush  out  1  line was M; owner must flush data.
- ram_addr  out  AWIDTH  to tag RAM addr.
- ram_din  out  DWIDTH  to tag RAM din.
- ram_we  out  1  to tag RAM we.
- ram_dout  in  DWIDTH  from tag RAM dout; valid the cycle after the address is latched.

Behaviour:
- State encoding: I = 00, S = 01, M = 10; 11 is treated as I (never a hit).
- Reset: FSM -> IDLE. All outputs 0, except ram_addr, which follows the latched index (cleared to 0). Streak counter = 0.
- FSM sequence: IDLE -> LOOKUP -> CMP -> RESP -> IDLE.
- IDLE:
  - Samples requests at the clock edge.
  - Grant priority: snoop first.
  - Exception: if cpu_req is pending and the streak counter = 2, the CPU is granted. This prevents CPU starvation.
  - Latches op, index, tag and state_in from the granted requester.
- LOOKUP: ram_addr = latched index. The RAM latches rd_addr at the end of this cycle.
- CMP:
  - ram_dout is valid; match = (dout tag == latched tag) and state in {S, M}.
  - Computes the update. If an update is required, ram_we = 1 for this cycle only, with ram_din = new entry; the write lands at the end of CMP.
  - Registers the results.
- RESP:
  - Exactly one of cpu_ack / snp_ack = 1 for this cycle.
  - Result outputs hold until the next RESP of the same requester.
- Latency: accept edge to ack = 3 cycles; 4 cycles per operation. No pipelining; one operation in flight.
- Update rules:
  - CPU lookup: no write.
  - CPU fill: always writes {cpu_state_in, cpu_tag}; cpu_hit / cpu_state_out reflect the prior contents (victim info).
  - Snoop BusRd: M hit -> write S, snp_flush = 1. S hit -> no write. Miss -> no write.
  - Snoop BusRdX: M hit -> write I (tag kept), snp_flush = 1. S hit -> write I. Miss -> no write.
- Streak counter (2 bits, saturating):
  - Increments on a snoop grant while cpu_req = 1.
  - Clears on a CPU grant, or when cpu_req = 0 at an IDLE sample.
- Simultaneous requests: snoop wins unless streak = 2. The loser stays pending, with its inputs stable.
- Request handshake: requesters must drop req by the edge ending RESP. A req still high in IDLE is a new request.
- ram_we is 0 in every state except CMP.
- Reset mid-operation: sequence aborted, no ack, ram_we forced 0 asynchronously. A write already completed at an earlier edge remains.

Test Plan:
- After reset, CPU fill idx 3, tag 0x1A5, state M -> cpu_ack in the 4th cycle; ram_we high exactly 1 cycle with din = {10, 0x1A5}. A subsequent CPU lookup idx 3, tag 0x1A5 -> cpu_hit = 1, state_out = 10, no ram_we.
- Snoop BusRd idx 3, tag 0x1A5 on M line -> snp_hit = 1, snp_flush = 1, RAM entry becomes {01, 0x1A5}. Repeat -> hit = 1, flush = 0, no write.
- Snoop BusRdX idx 3, tag 0x1A5 on S line -> hit = 1, flush = 0, entry = {00, 0x1A5}. A CPU lookup then returns hit = 0, state_out = 00.
- cpu_req and snp_req asserted together in the same cycle, snoop held continuously -> grant order snoop, snoop, CPU, snoop; CPU ack no later than the 3rd grant.
- Tag mismatch (lookup idx 5, tag 0x000 vs stored 0x0FF, S) -> cpu_hit = 0, state_out = 01. Index 7 wrap (max) behaves identically.
- Assert reset during CMP of a fill -> ram_we drops immediately, no ack, FSM in IDLE; a later lookup of that index returns the old contents.

Source files
------------

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - cache tag RAM sequencer arbitrating CPU lookup/fill against bus snoops
module cache_tag_ctrl #(
    parameter  int AWIDTH = 3,
    parameter  int DWIDTH = 11,
    localparam int TWIDTH = DWIDTH - 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_op,
    input  logic [AWIDTH-1:0] cpu_index,
    input  logic [TWIDTH-1:0] cpu_tag,
    input  logic [1:0]        cpu_state_in,
    output logic              cpu_ack,
    output logic              cpu_hit,
    output logic [1:0]        cpu_state_out,
    input  logic              snp_req,
    input  logic              snp_op,
    input  logic [AWIDTH-1:0] snp_index,
    input  logic [TWIDTH-1:0] snp_tag,
    output logic              snp_ack,
    output logic              snp_hit,
    output logic              snp_flush,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [1:0] {IDLE, LOOKUP, CMP, RESP} fsm_t;

    fsm_t              state_q, state_d;
    logic              who_q, who_d;
    logic              op_q, op_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic [TWIDTH-1:0] tag_q, tag_d;
    logic [1:0]        st_in_q, st_in_d;
    logic [1:0]        streak_q, streak_d;
    logic              cpu_hit_q, cpu_hit_d;
    logic [1:0]        cpu_state_q, cpu_state_d;
    logic              snp_hit_q, snp_hit_d;
    logic              snp_flush_q, snp_flush_d;

    logic [TWIDTH-1:0] dout_tag;
    logic [1:0]        dout_st;
    logic              match;
    logic              snp_grant;

    assign dout_tag = ram_dout[TWIDTH-1:0];
    assign dout_st  = ram_dout[DWIDTH-1:TWIDTH];
    assign match    = (dout_tag == tag_q) && (dout_st == ST_S || dout_st == ST_M);
    // Snoop normally wins; after two consecutive snoop wins over a waiting CPU, the CPU goes first.
    assign snp_grant = snp_req && !(cpu_req && streak_q == 2'd2);

    assign ram_addr      = idx_q;
    assign cpu_hit       = cpu_hit_q;
    assign cpu_state_out = cpu_state_q;
    assign snp_hit       = snp_hit_q;
    assign snp_flush     = snp_flush_q;

    always_comb begin
        state_d     = state_q;
        who_d       = who_q;
        op_d        = op_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        st_in_d     = st_in_q;
        streak_d    = streak_q;
        cpu_hit_d   = cpu_hit_q;
        cpu_state_d = cpu_state_q;
        snp_hit_d   = snp_hit_q;
        snp_flush_d = snp_flush_q;
        ram_we      = 1'b0;
        ram_din     = '0;
        cpu_ack     = 1'b0;
        snp_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (snp_grant) begin
                    who_d    = 1'b1;
                    op_d     = snp_op;
                    idx_d    = snp_index;
                    tag_d    = snp_tag;
                    st_in_d  = ST_I;
                    streak_d = !cpu_req ? 2'd0 : (streak_q == 2'd3 ? 2'd3 : streak_q + 2'd1);
                    state_d  = LOOKUP;
                end else if (cpu_req) begin
                    who_d    = 1'b0;
                    op_d     = cpu_op;
                    idx_d    = cpu_index;
                    tag_d    = cpu_tag;
                    st_in_d  = cpu_state_in;
                    streak_d = 2'd0;
                    state_d  = LOOKUP;
                end else begin
                    streak_d = 2'd0;
                end
            end
            LOOKUP: state_d = CMP;
            CMP: begin
                if (who_q) begin
                    snp_hit_d   = match;
                    snp_flush_d = match && (dout_st == ST_M);
                    // BusRd demotes M to S; BusRdX invalidates any hit, keeping the tag.
                    if (match && (op_q || dout_st == ST_M)) begin
                        ram_we  = 1'b1;
                        ram_din = {(op_q ? ST_I : ST_S), dout_tag};
                    end
                end else begin
                    cpu_hit_d   = match;
                    cpu_state_d = dout_st;
                    if (op_q) begin
                        ram_we  = 1'b1;
                        ram_din = {st_in_q, tag_q};
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                cpu_ack = !who_q;
                snp_ack = who_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            who_q       <= 1'b0;
            op_q        <= 1'b0;
            idx_q       <= '0;
            tag_q       <= '0;
            st_in_q     <= ST_I;
            streak_q    <= 2'd0;
            cpu_hit_q   <= 1'b0;
            cpu_state_q <= ST_I;
            snp_hit_q   <= 1'b0;
            snp_flush_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            who_q       <= who_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            st_in_q     <= st_in_d;
            streak_q    <= streak_d;
            cpu_hit_q   <= cpu_hit_d;
            cpu_state_q <= cpu_state_d;
            snp_hit_q   <= snp_hit_d;
            snp_flush_q <= snp_flush_d;
        end
    end

endmodule
